// File: rtl/aes128_iter_behav_if.sv
// AXI-Stream interface bundle shared by the AES core and its surroundings.
// tkeep is carried for completeness; the AES input side ignores it.
interface axis_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic               tvalid;
    logic               tready;
    logic [WIDTH-1:0]   tdata;
    logic [WIDTH/8-1:0] tkeep;
    logic               tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/aes128_iter_behav.sv
// Iterative AES-128 encryptor on AXI-Stream: one round per clock, key expanded on the fly.
// Stream: key, [IV], then plaintext blocks; ciphertext out, input/output never overlap.
// Optional CBC chaining is built when the macro AES_CBC_EN is defined (default: pure ECB).
// Byte i of a 128-bit block (FIPS order) lives in bits [8i+7:8i].
module aes128_iter_behav #(
    parameter int unsigned S_AXIS_WIDTH = 32,
    parameter int unsigned M_AXIS_WIDTH = 32
) (
    input logic    Clk,
    input logic    Rst_n,
    axis_if.slave  S_axis,
    axis_if.master M_axis
);
    localparam int unsigned InBeats  = 128 / S_AXIS_WIDTH;
    localparam int unsigned OutBeats = 128 / M_AXIS_WIDTH;
    localparam int unsigned InCntW   = (InBeats > 1) ? $clog2(InBeats) : 1;
    localparam int unsigned OutCntW  = (OutBeats > 1) ? $clog2(OutBeats) : 1;

    typedef enum logic [4:0] {
        StKeyIn = 5'b00001,
`ifdef AES_CBC_EN
        StIvIn  = 5'b00010,
`endif
        StPtIn  = 5'b00100,
        StRound = 5'b01000,
        StCtOut = 5'b10000
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot, tmp, n0, n1, n2, n3;
        rot = {k[103:96], k[127:104]};  // RotWord in little-endian byte packing
        tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {24'h0, rc};
        n0  = k[31:0] ^ tmp;
        n1  = k[63:32] ^ n0;
        n2  = k[95:64] ^ n1;
        n3  = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic final_rnd);
        logic [7:0]   sb [16];
        logic [127:0] sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[8*i +: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) sr[8*(4*c+r) +: 8] = sb[4*((c+r)%4)+r];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[32*c +: 8];
            a1 = sr[32*c+8 +: 8];
            a2 = sr[32*c+16 +: 8];
            a3 = sr[32*c+24 +: 8];
            mc[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return (final_rnd ? sr : mc) ^ rk;
    endfunction

    state_e               state_q, state_d;
    logic [InCntW-1:0]    in_cnt_q, in_cnt_d;
    logic [OutCntW-1:0]   out_cnt_q, out_cnt_d;
    logic [3:0]           rnd_q, rnd_d;
    logic [127:0]         in_buf_q, in_buf_d;
    logic [127:0]         key_q, key_d;
    logic [127:0]         rk_q, rk_d;
    logic [127:0]         aes_q, aes_d;
    logic [127:0]         ct_q, ct_d;
    logic                 last_q, last_d;
    logic [127:0]         chain;
`ifdef AES_CBC_EN
    logic [127:0]         chain_q, chain_d;
    assign chain = chain_q;
`else
    assign chain = '0;
`endif

    logic                      in_hs, out_hs;
    logic [S_AXIS_WIDTH+127:0] in_cat;
    logic [127:0]              in_next, rk_next, rnd_res;

    assign in_hs   = S_axis.tvalid && S_axis.tready;
    assign out_hs  = M_axis.tvalid && M_axis.tready;
    // New beat enters at the top; after a full phase the first beat sits in the low bits
    assign in_cat  = {S_axis.tdata, in_buf_q};
    assign in_next = in_cat[S_axis_top() -: 128];
    assign rk_next = key_expand(rk_q, rcon(rnd_q));
    assign rnd_res = aes_round(aes_q, rk_next, rnd_q == 4'd10);

    function automatic int unsigned S_axis_top();
        return S_AXIS_WIDTH + 127;
    endfunction

    // Next-state and datapath updates for the phase FSM
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        rnd_d     = rnd_q;
        in_buf_d  = in_buf_q;
        key_d     = key_q;
        rk_d      = rk_q;
        aes_d     = aes_q;
        ct_d      = ct_q;
        last_d    = last_q;
`ifdef AES_CBC_EN
        chain_d   = chain_q;
`endif
        unique case (state_q)
            StKeyIn: if (in_hs) begin
                in_buf_d = in_next;
                if (in_cnt_q == '0) begin
                    key_d    = in_next;
                    in_cnt_d = InCntW'(InBeats - 1);
`ifdef AES_CBC_EN
                    state_d  = StIvIn;
`else
                    state_d  = StPtIn;
`endif
                end else begin
                    in_cnt_d = in_cnt_q - 1'b1;
                end
            end
`ifdef AES_CBC_EN
            StIvIn: if (in_hs) begin
                in_buf_d = in_next;
                if (in_cnt_q == '0) begin
                    chain_d  = in_next;
                    in_cnt_d = InCntW'(InBeats - 1);
                    state_d  = StPtIn;
                end else begin
                    in_cnt_d = in_cnt_q - 1'b1;
                end
            end
`endif
            StPtIn: if (in_hs) begin
                in_buf_d = in_next;
                if (in_cnt_q == '0) begin
                    aes_d    = in_next ^ chain ^ key_q;
                    rk_d     = key_q;
                    rnd_d    = 4'd1;
                    last_d   = S_axis.tlast;  // only the block's final beat counts
                    in_cnt_d = InCntW'(InBeats - 1);
                    state_d  = StRound;
                end else begin
                    in_cnt_d = in_cnt_q - 1'b1;
                end
            end
            StRound: begin
                rk_d  = rk_next;
                aes_d = rnd_res;
                if (rnd_q == 4'd10) begin
                    ct_d      = rnd_res;
`ifdef AES_CBC_EN
                    chain_d   = rnd_res;
`endif
                    out_cnt_d = OutCntW'(OutBeats - 1);
                    state_d   = StCtOut;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            StCtOut: if (out_hs) begin
                ct_d = ct_q >> M_AXIS_WIDTH;
                if (out_cnt_q == '0) begin
                    in_cnt_d = InCntW'(InBeats - 1);
                    state_d  = last_q ? StKeyIn : StPtIn;
                end else begin
                    out_cnt_d = out_cnt_q - 1'b1;
                end
            end
            default: state_d = StKeyIn;
        endcase
    end

    // State registers; reset discards any partial key, IV, block or output
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= StKeyIn;
            in_cnt_q  <= InCntW'(InBeats - 1);
            out_cnt_q <= '0;
            rnd_q     <= '0;
            in_buf_q  <= '0;
            key_q     <= '0;
            rk_q      <= '0;
            aes_q     <= '0;
            ct_q      <= '0;
            last_q    <= 1'b0;
`ifdef AES_CBC_EN
            chain_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            rnd_q     <= rnd_d;
            in_buf_q  <= in_buf_d;
            key_q     <= key_d;
            rk_q      <= rk_d;
            aes_q     <= aes_d;
            ct_q      <= ct_d;
            last_q    <= last_d;
`ifdef AES_CBC_EN
            chain_q   <= chain_d;
`endif
        end
    end

    // Stream outputs decoded from the current state
    always_comb begin
        S_axis.tready = (state_q == StKeyIn) || (state_q == StPtIn);
`ifdef AES_CBC_EN
        if (state_q == StIvIn) S_axis.tready = 1'b1;
`endif
        M_axis.tvalid = (state_q == StCtOut);
        M_axis.tdata  = M_axis.tvalid ? ct_q[M_AXIS_WIDTH-1:0] : '0;
        M_axis.tkeep  = M_axis.tvalid ? '1 : '0;
        M_axis.tlast  = M_axis.tvalid && last_q && (out_cnt_q == '0);
    end
endmodule

// File: tb/tb_aes128_iter_behav.sv
// Self-checking bench for aes128_iter_behav: FIPS-197 / SP800-38A vectors through a scoreboard.
// Default build exercises ECB at 32/32; with AES_CBC_EN it exercises CBC at 8/128.
module tb_aes128_iter_behav;
`ifdef AES_CBC_EN
    localparam int unsigned SW = 8;
    localparam int unsigned MW = 128;
`else
    localparam int unsigned SW = 32;
    localparam int unsigned MW = 32;
`endif
    localparam int unsigned InBeats  = 128 / SW;
    localparam int unsigned OutBeats = 128 / MW;

    // Vectors in FIPS byte order (byte 0 leftmost)
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] E1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] E2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] E3 = 128'h43b1cd7f598ece23881b00e3ed030688;
    localparam logic [127:0] P4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] E4 = 128'h7b0c785e27e8ad3f8223207104725dd4;
    localparam logic [127:0] CB1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CB2 = 128'h5086cb9b507219ee95db113a917678b2;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    axis_if #(.WIDTH(SW)) s_if ();
    axis_if #(.WIDTH(MW)) m_if ();

    aes128_iter_behav #(.S_AXIS_WIDTH(SW), .M_AXIS_WIDTH(MW)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .S_axis (s_if.slave),
        .M_axis (m_if.master)
    );

    int checks = 0;
    int errors = 0;
    int tr_mode = 0;  // 0: tready high, 1: random tready + input gaps, 2: tready low

    typedef struct {
        logic [127:0] ct;
        bit           last;
    } exp_t;
    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] le(input logic [127:0] f);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = f[127-8*i -: 8];
        return r;
    endfunction

    function automatic exp_t mk(input logic [127:0] fips_ct, input bit last);
        exp_t e;
        e.ct   = le(fips_ct);
        e.last = last;
        return e;
    endfunction

    // Output-side tready pattern
    always @(posedge Clk) begin
        #1;
        if (tr_mode == 0)      m_if.tready = 1'b1;
        else if (tr_mode == 1) m_if.tready = 1'($urandom_range(0, 1));
        else                   m_if.tready = 1'b0;
    end

    // Monitor: assembles output beats, checks stall stability and pops the scoreboard
    int           beat_n = 0;
    logic [127:0] acc = '0;
    bit           stall_v = 0;
    logic [MW-1:0] stall_d;
    logic         stall_l;
    always @(negedge Clk) begin
        if (!Rst_n) begin
            beat_n  = 0;
            acc     = '0;
            stall_v = 0;
        end else begin
            if (stall_v) begin
                check_eq("stall_tvalid", 128'(m_if.tvalid), 128'(1));
                check_eq("stall_tdata", 128'(m_if.tdata), 128'(stall_d));
                check_eq("stall_tlast", 128'(m_if.tlast), 128'(stall_l));
                stall_v = 0;
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 128'(m_if.tvalid), 128'(0));
                end else begin
                    check_eq("out_tlast", 128'(m_if.tlast),
                             128'(exp_q[0].last && (beat_n == int'(OutBeats) - 1)));
                    check_eq("out_tkeep", 128'(m_if.tkeep), 128'({(MW/8){1'b1}}));
                    check_eq("in_tready_during_out", 128'(s_if.tready), 128'(0));
                    acc = acc | (128'(m_if.tdata) << (MW * beat_n));
                    beat_n++;
                    if (beat_n == int'(OutBeats)) begin
                        check_eq("ciphertext", acc, exp_q[0].ct);
                        void'(exp_q.pop_front());
                        beat_n = 0;
                        acc    = '0;
                    end
                end
            end else if (m_if.tvalid) begin
                stall_v = 1;
                stall_d = m_if.tdata;
                stall_l = m_if.tlast;
            end
        end
    end

    // Drive one 128-bit word (FIPS order); stray_beat >= 0 raises tlast on that non-final beat
    task automatic send_vec(input logic [127:0] fips, input bit last, input int stray_beat);
        logic [127:0] v;
        int t;
        v = le(fips);
        for (int b = 0; b < int'(InBeats); b++) begin
            if (tr_mode == 1) begin
                repeat ($urandom_range(0, 2)) @(posedge Clk);
                #1;
            end
            s_if.tdata  = v[SW*b +: SW];
            s_if.tlast  = (b == int'(InBeats) - 1) ? last : (b == stray_beat);
            s_if.tvalid = 1'b1;
            t = 0;
            forever begin
                @(negedge Clk);
                if (s_if.tready) break;
                t++;
                if (t > 2000) begin
                    $display("FAIL in_handshake_timeout beat %0d", b);
                    $fatal(1);
                end
            end
            @(posedge Clk);
            #1;
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [127:0] key);
        send_vec(key, 1'b0, -1);
`ifdef AES_CBC_EN
        send_vec(K0, 1'b0, -1);  // IV 000102..0f
`endif
    endtask

    task automatic check_latency();
        repeat (9) @(posedge Clk);
        #1;
        check_eq("tvalid_before_e10", 128'(m_if.tvalid), 128'(0));
        @(posedge Clk);
        #1;
        check_eq("tvalid_at_e10", 128'(m_if.tvalid), 128'(1));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(posedge Clk);
            t++;
        end
        #1;
        check_eq("drain_pending", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic pulse_reset();
        Rst_n = 1'b0;
        #1;
        check_eq("rst_tvalid", 128'(m_if.tvalid), 128'(0));
        check_eq("rst_tdata", 128'(m_if.tdata), 128'(0));
        check_eq("rst_tlast", 128'(m_if.tlast), 128'(0));
        check_eq("rst_in_tready", 128'(s_if.tready), 128'(1));
        @(negedge Clk);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int t;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '1;
        m_if.tready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("reset_in_tready", 128'(s_if.tready), 128'(1));
        check_eq("reset_tvalid", 128'(m_if.tvalid), 128'(0));
        check_eq("reset_tdata", 128'(m_if.tdata), 128'(0));
        check_eq("reset_tkeep", 128'(m_if.tkeep), 128'(0));
        check_eq("reset_tlast", 128'(m_if.tlast), 128'(0));
        Rst_n = 1'b1;

`ifndef AES_CBC_EN
        // FIPS-197 C.1 single block with latency check
        send_hdr(K0);
        exp_q.push_back(mk(C0, 1'b1));
        send_vec(P0, 1'b1, -1);
        check_latency();
        wait_drain();

        // Multi-block packet, key sent once, random backpressure and input gaps
        tr_mode = 1;
        send_hdr(K1);
        exp_q.push_back(mk(E1, 1'b0));
        send_vec(P1, 1'b0, -1);
        exp_q.push_back(mk(E1, 1'b0));
        send_vec(P1, 1'b0, -1);
        exp_q.push_back(mk(E2, 1'b0));
        send_vec(P2, 1'b0, -1);
        exp_q.push_back(mk(E3, 1'b0));
        send_vec(P3, 1'b0, -1);
        exp_q.push_back(mk(E4, 1'b1));
        send_vec(P4, 1'b1, -1);
        wait_drain();
        tr_mode = 0;

        // Stray tlast on beat 2 of 4 must not end the packet
        send_hdr(K1);
        exp_q.push_back(mk(E4, 1'b0));
        send_vec(P4, 1'b0, 1);
        exp_q.push_back(mk(E2, 1'b1));
        send_vec(P2, 1'b1, -1);
        wait_drain();
`else
        // SP800-38A CBC, two blocks, tlast on the second only
        send_hdr(K1);
        exp_q.push_back(mk(CB1, 1'b0));
        send_vec(P1, 1'b0, -1);
        check_latency();
        exp_q.push_back(mk(CB2, 1'b1));
        send_vec(P2, 1'b1, -1);
        wait_drain();

        // Same packet again: IV re-read, with backpressure and input gaps
        tr_mode = 1;
        send_hdr(K1);
        exp_q.push_back(mk(CB1, 1'b0));
        send_vec(P1, 1'b0, -1);
        exp_q.push_back(mk(CB2, 1'b1));
        send_vec(P2, 1'b1, -1);
        wait_drain();
        tr_mode = 0;
`endif

        // Reset during round 5: nothing may come out for the aborted block
        send_hdr(K0);
        send_vec(P0, 1'b1, -1);
        repeat (5) @(posedge Clk);
        #2;
        pulse_reset();

        // Reset while ciphertext is held under backpressure
        tr_mode = 2;
        send_hdr(K0);
        send_vec(P0, 1'b1, -1);
        t = 0;
        while (!m_if.tvalid && t < 100) begin
            @(posedge Clk);
            #1;
            t++;
        end
        check_eq("held_tvalid", 128'(m_if.tvalid), 128'(1));
        pulse_reset();
        tr_mode = 0;

        // Fresh packet after reset gives the reference result
        send_hdr(K1);
`ifdef AES_CBC_EN
        exp_q.push_back(mk(CB1, 1'b1));
`else
        exp_q.push_back(mk(E1, 1'b1));
`endif
        send_vec(P1, 1'b1, -1);
        wait_drain();

        repeat (3) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes128_iter_behav.md
# aes128_iter_behav

Iterative AES-128 encryptor on AXI-Stream, one cipher round per clock, with on-the-fly key expansion. It trades the fully unrolled datapath for one shared round (SubBytes, ShiftRows, MixColumns, AddRoundKey) plus one key-expansion step. It adds optional CBC chaining and sits in the same stream position as the existing ECB cores: key, then data blocks in, ciphertext out.

## Interface
- S_AXIS_WIDTH, 32: input beat width; one of 8/32/64/128.
- M_AXIS_WIDTH, 32: output beat width; one of 8/32/64/128.
- Clk  input  1  clock; all state changes on its rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- S_axis  axis_if.slave  S_AXIS_WIDTH  key, IV, plaintext in; tvalid/tready/tdata/tlast used, tkeep ignored.
- M_axis  axis_if.master  M_AXIS_WIDTH  ciphertext out; tvalid/tready/tdata/tkeep/tlast driven.

## Operation
- States (one-hot): ST_KEY_IN, ST_IV_IN (CBC build only), ST_PLAINTEXT_IN, ST_ROUND, ST_CIPHERTEXT_OUT.
- Packet format: key (128/S_AXIS_WIDTH beats), IV (CBC only, 128/S_AXIS_WIDTH beats), then N ≥ 1 plaintext blocks.
- tlast is sampled only on the final beat of a plaintext block. It marks the last block of the packet. tlast on any other beat is ignored.
- Beat packing: the first beat lands in bits [S_AXIS_WIDTH-1:0]. Each new beat is shifted in at the top. FIPS byte 0 = tdata[7:0] of the first beat.
- S_axis.tready = 1 in ST_KEY_IN, ST_IV_IN and ST_PLAINTEXT_IN; 0 otherwise.
- Last plaintext beat accepted:
  - state_reg <= block ^ chain ^ key_reg; chain = 0 for ECB.
  - round_key_reg <= key_reg; round counter <= 1; go to ST_ROUND.
- ST_ROUND, round r = 1..10:
  - round_key_reg <= expand(round_key_reg, rcon[r]).
  - state_reg <= round(state_reg, expanded key); MixColumns is skipped when r = 10.
  - After r = 10: ciphertext_reg <= result; in CBC, chain_reg <= result; go to ST_CIPHERTEXT_OUT.
- key_reg holds the original key unchanged for reuse across all blocks of a packet.
- ST_CIPHERTEXT_OUT:
  - tvalid = 1, tdata = ciphertext_reg[M_AXIS_WIDTH-1:0], tkeep all ones.
  - tlast = captured tlast, asserted on the final output beat only.
  - Each handshake shifts ciphertext_reg right by M_AXIS_WIDTH.
- After the final output beat: go to ST_KEY_IN if tlast was captured, else ST_PLAINTEXT_IN.
- Outside ST_CIPHERTEXT_OUT: tvalid, tdata, tkeep and tlast are all 0.
- Beat counters reload to (beats per phase − 1) on each phase entry. They decrement on each handshake and never wrap mid-phase.

## Timing
- Reset (asynchronous, Rst_n low) immediately:
  - Clears all registers; state = ST_KEY_IN.
  - Outputs: S_axis.tready = 1, M_axis.tvalid/tdata/tkeep/tlast = 0.
  - Any partial key, IV, block or output is discarded.
- Release: the first key beat may be accepted on the first rising edge with Rst_n high.
- Latency: the last plaintext beat is accepted on edge E0. There are 10 ST_ROUND cycles. M_axis.tvalid rises on edge E10, 10 cycles after E0.
- Throughput, 32/32 widths: 4 in + 10 round + 4 out = 18 cycles per block with tready always high.
- M_axis.tready low holds tdata/tlast stable. No input is accepted until the output block drains; input and output never overlap.
- S_axis.tvalid gaps stall only the beat counter; no timeout.
- Width 128: one beat per phase; the counter is a single zero bit.

## Configuration
- AES_CBC_EN defined:
  - ST_IV_IN and chain_reg are present; block i is encrypted as E(P_i ^ C_{i-1}) with C_0 = IV.
  - The IV is re-read for every packet.
- AES_CBC_EN undefined:
  - ST_IV_IN, chain_reg and the XOR are removed; pure ECB.
  - ST_KEY_IN goes directly to ST_PLAINTEXT_IN.

## Test plan
- ECB, 32/32: key 000102…0f, plaintext 00112233…eeff with tlast → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, tvalid exactly 10 cycles after the last input beat, tlast on beat 4, then back to ST_KEY_IN.
- CBC, AES_CBC_EN, 8/128: key 2b7e1516…09cf4f3c, IV 000102…0f, blocks 6bc1bee2…7393172a and ae2d8a57…45af8e51 → 7649abac…12e9197d then 5086cb9b…917678b2; tlast on the second block only.
- ECB multi-block, no tlast on the first block: key 2b7e…4f3c, block 6bc1…172a twice → 3ad77bb40d7a3660a89ecaf32466ef97 twice; the key is sent only once.
- Backpressure: M_axis.tready toggles randomly → tdata stable while stalled, no beat lost or duplicated, S_axis.tready = 0 until drained.
- Mid-round reset: Rst_n low in round 5 → tvalid drops immediately; the next packet with a fresh key gives the correct FIPS-197 result.
- tlast on a non-final plaintext beat (beat 2 of 4) → ignored; output tlast follows the block's final beat only.
